// File: rtl/mc_datapath_pkg.sv
// Shared types for the multi-cycle RV32I-subset datapath.
// FSM states, opcodes, ALU operations and access-size encodings.
package mc_pkg;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLT,
        ALU_SLTU,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA
    } aluOp_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    // bit30 selects SUB (register form only) and SRA
    function automatic aluOp_t aluDecode(
        input logic [2:0] funct3,
        input logic       bit30,
        input logic       isReg
    );
        aluOp_t op;
        op = ALU_ADD;
        unique case (funct3)
            3'b000: op = (isReg && bit30) ? ALU_SUB : ALU_ADD;
            3'b001: op = ALU_SLL;
            3'b010: op = ALU_SLT;
            3'b011: op = ALU_SLTU;
            3'b100: op = ALU_XOR;
            3'b101: op = bit30 ? ALU_SRA : ALU_SRL;
            3'b110: op = ALU_OR;
            3'b111: op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/mc_datapath_alu.sv
// Shared combinational ALU for the multi-cycle datapath.
// Shifts use only the low five bits of b; arithmetic wraps.
module mc_alu
    import mc_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  aluOp_t            op,
    input  logic [DWIDTH-1:0] a,
    input  logic [DWIDTH-1:0] b,
    output logic [DWIDTH-1:0] y
);

    logic [4:0] shamt;

    assign shamt = b[4:0];

    always_comb begin
        y = '0;
        unique case (op)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_AND:  y = a & b;
            ALU_OR:   y = a | b;
            ALU_XOR:  y = a ^ b;
            ALU_SLT:  y = DWIDTH'($signed(a) < $signed(b));
            ALU_SLTU: y = DWIDTH'(a < b);
            ALU_SLL:  y = a << shamt;
            ALU_SRL:  y = a >> shamt;
            ALU_SRA:  y = $signed(a) >>> shamt;
            default:  y = '0;
        endcase
    end

endmodule

// File: rtl/mc_datapath.sv
// Multi-cycle RV32I-subset datapath with ready/valid memory ports.
// Define MC_DATAPATH_RETIRE_CNT_EN to add the 64-bit instret counter.
module mc_datapath
    import mc_pkg::*;
#(
    parameter int                DWIDTH   = 32,
    parameter int                NREGS    = 32,
    parameter logic [DWIDTH-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [DWIDTH-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_ready,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [1:0]        dmem_size,
    output logic [DWIDTH-1:0] dmem_addr,
    output logic [DWIDTH-1:0] dmem_wdata,
    input  logic [DWIDTH-1:0] dmem_rdata,
    input  logic              dmem_ready,
    output logic              halted,
    output logic [DWIDTH-1:0] pc_out
`ifdef MC_DATAPATH_RETIRE_CNT_EN
    ,
    output logic [63:0]       instret
`endif
);

    localparam int AW = $clog2(NREGS);

    state_t            state;
    state_t            nextState;
    logic [DWIDTH-1:0] pc;
    logic [31:0]       ir;
    logic [DWIDTH-1:0] regA;
    logic [DWIDTH-1:0] regB;
    logic [DWIDTH-1:0] aluOut;
    logic [DWIDTH-1:0] mdr;
    logic [DWIDTH-1:0] rf [NREGS];

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [AW-1:0]     rd;
    logic [AW-1:0]     rs1;
    logic [AW-1:0]     rs2;
    logic              isR;
    logic              isI;
    logic              isLoad;
    logic              isStore;
    logic              isBranch;
    logic              isJal;
    logic              legalOp;
    logic              brLegal;
    logic              brTaken;

    logic signed [31:0] imm32;
    logic [DWIDTH-1:0] imm;
    logic [DWIDTH-1:0] pcPlus4;
    logic [DWIDTH-1:0] pcTarget;
    logic [DWIDTH-1:0] ldExt;

    aluOp_t            aluOp;
    logic [DWIDTH-1:0] aluA;
    logic [DWIDTH-1:0] aluB;
    logic [DWIDTH-1:0] aluRes;

    assign opcode   = ir[6:0];
    assign funct3   = ir[14:12];
    assign rd       = ir[7 +: AW];
    assign rs1      = ir[15 +: AW];
    assign rs2      = ir[20 +: AW];

    assign isR      = (opcode == OP_R);
    assign isI      = (opcode == OP_I);
    assign isLoad   = (opcode == OP_LOAD);
    assign isStore  = (opcode == OP_STORE);
    assign isBranch = (opcode == OP_BRANCH);
    assign isJal    = (opcode == OP_JAL);
    assign legalOp  = isR | isI | isLoad | isStore | isBranch | isJal;
    assign brLegal  = (funct3[2:1] == 2'b00);

    // Branch compare reuses the ALU subtract; funct3[0] flips BEQ into BNE
    assign brTaken  = (aluRes == '0) ^ funct3[0];

    always_comb begin
        imm32 = {{20{ir[31]}}, ir[31:20]};
        unique case (1'b1)
            isStore:  imm32 = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            isBranch: imm32 = {{20{ir[31]}}, ir[7], ir[30:25],
                               ir[11:8], 1'b0};
            isJal:    imm32 = {{12{ir[31]}}, ir[19:12], ir[20],
                               ir[30:21], 1'b0};
            default:  imm32 = {{20{ir[31]}}, ir[31:20]};
        endcase
    end

    assign imm      = DWIDTH'(imm32);
    assign pcPlus4  = pc + DWIDTH'(4);
    assign pcTarget = pc + imm;

    always_comb begin
        aluOp = ALU_ADD;
        aluA  = regA;
        aluB  = imm;
        unique case (1'b1)
            isBranch: begin
                aluOp = ALU_SUB;
                aluB  = regB;
            end
            isJal: begin
                aluA = pc;
                aluB = DWIDTH'(4);
            end
            isR: begin
                aluOp = aluDecode(funct3, ir[30], 1'b1);
                aluB  = regB;
            end
            isI:     aluOp = aluDecode(funct3, ir[30], 1'b0);
            default: aluOp = ALU_ADD;
        endcase
    end

    mc_alu #(
        .DWIDTH(DWIDTH)
    ) uAlu (
        .op(aluOp),
        .a (aluA),
        .b (aluB),
        .y (aluRes)
    );

    always_comb begin
        ldExt = dmem_rdata;
        unique case (funct3[1:0])
            SIZE_BYTE: ldExt = funct3[2]
                ? DWIDTH'(dmem_rdata[7:0])
                : DWIDTH'($signed(dmem_rdata[7:0]));
            SIZE_HALF: ldExt = funct3[2]
                ? DWIDTH'(dmem_rdata[15:0])
                : DWIDTH'($signed(dmem_rdata[15:0]));
            default:   ldExt = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        unique case (state)
            FETCH:  if (imem_ready) nextState = DECODE;
            DECODE: nextState = legalOp ? EXEC : HALT;
            EXEC: begin
                unique case (1'b1)
                    isBranch:         nextState = brLegal ? FETCH : HALT;
                    isLoad || isStore: nextState = MEM;
                    default:          nextState = WB;
                endcase
            end
            MEM:    if (dmem_ready) nextState = isStore ? FETCH : WB;
            WB:     nextState = FETCH;
            HALT:   nextState = HALT;
            default: nextState = FETCH;
        endcase
    end

    // Requests are gated by reset so they drop the instant it asserts
    always_comb begin
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_size  = SIZE_BYTE;
        dmem_addr  = '0;
        dmem_wdata = '0;
        if (reset) begin
            unique case (state)
                FETCH: imem_req = 1'b1;
                MEM: begin
                    dmem_req   = 1'b1;
                    dmem_we    = isStore;
                    dmem_size  = funct3[1:0];
                    dmem_addr  = aluOut;
                    dmem_wdata = regB;
                end
                default: ;
            endcase
        end
    end

    assign halted    = (state == HALT);
    assign imem_addr = pc;
    assign pc_out    = pc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc     <= RESET_PC;
            ir     <= '0;
            regA   <= '0;
            regB   <= '0;
            aluOut <= '0;
            mdr    <= '0;
        end else begin
            unique case (state)
                FETCH: if (imem_ready) ir <= imem_rdata;
                DECODE: begin
                    regA <= rf[rs1];
                    regB <= rf[rs2];
                end
                EXEC: begin
                    aluOut <= aluRes;
                    unique case (1'b1)
                        isJal: pc <= pcTarget;
                        isBranch: begin
                            if (brLegal) pc <= brTaken ? pcTarget : pcPlus4;
                        end
                        default: pc <= pcPlus4;
                    endcase
                end
                MEM: if (dmem_ready && !isStore) mdr <= ldExt;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
        end else if (state == WB && rd != '0) begin
            rf[rd] <= isLoad ? mdr : aluOut;
        end
    end

`ifdef MC_DATAPATH_RETIRE_CNT_EN
    logic retireEv;

    assign retireEv = (state == WB)
        || (state == MEM && isStore && dmem_ready)
        || (state == EXEC && isBranch && brLegal);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instret <= '0;
        end else if (retireEv) begin
            instret <= instret + 64'd1;
        end
    end
`endif

endmodule

// File: doc/mc_datapath.md
Name: mc_datapath

Overview:
- Parametrised multi-cycle RV32I-subset datapath.
- Successor to the single-cycle datapath: internal FSM sequences FETCH/DECODE/EXEC/MEM/WB over one shared ALU.
- Adds ready/valid handshakes to external instruction and data memories, so wait-state memories are tolerated.
- Sits between the core top level and the memory subsystem.

Parameters:
- DWIDTH, 32: datapath and address width.
- NREGS, 32: register-file depth; x0 is hardwired to 0; AW = clog2(NREGS).
- RESET_PC, 0: PC value loaded on reset.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  DWIDTH  fetch address (equals PC).
- imem_rdata  in  32  instruction word.
- imem_ready  in  1  fetch data valid.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store, 0 = load.
- dmem_size  out  2  access size: 00 byte, 01 half, 10 word.
- dmem_addr  out  DWIDTH  effective address.
- dmem_wdata  out  DWIDTH  store data, right-aligned.
- dmem_rdata  in  DWIDTH  load data, right-aligned, unextended.
- dmem_ready  in  1  access complete.
- halted  out  1  sticky; set on illegal opcode.
- pc_out  out  DWIDTH  current PC, for debug.

Behaviour:
- Reset (reset=0): state=FETCH; PC=RESET_PC; IR, A, B, ALUOUT, MDR=0; all registers=0; all outputs 0 except imem_addr/pc_out=RESET_PC.
- FETCH:
  - imem_req=1 with imem_addr=PC, held stable until imem_ready is sampled 1.
  - That same edge: IR<=imem_rdata; go to DECODE.
  - Zero wait states gives a 1-cycle FETCH.
- DECODE:
  - A<=rf[rs1], B<=rf[rs2]; immediate generated from IR (I/S/B/J formats).
  - Opcode not in {0110011, 0010011, 0000011, 0100011, 1100011, 1101111} -> HALT.
- EXEC:
  - ALUOUT<=result.
  - R/I ALU ops: ADD, SUB (R only, funct7[5]), AND, OR, XOR, SLT, SLTU, SLL, SRL, SRA.
  - Load/store: A+imm.
  - JAL: ALUOUT<=PC+4; PC<=PC+immJ.
  - Branch, BEQ/BNE only: PC<=taken ? PC+immB : PC+4; then FETCH.
  - Other funct3 under the branch opcode -> HALT.
  - All shifts use only B[4:0] / imm[4:0]. Arithmetic wraps mod 2^DWIDTH.
- Next state after EXEC: load/store -> MEM; ALU/JAL -> WB. Non-branch, non-JAL instructions set PC<=PC+4 in EXEC.
- MEM:
  - dmem_req=1; dmem_we=1 for store; dmem_addr=ALUOUT; dmem_size=funct3[1:0]; dmem_wdata=B.
  - All outputs held stable until dmem_ready=1.
  - Load: MDR<=dmem_rdata, sign- or zero-extended per funct3[2] (LBU/LHU); go to WB.
  - Store: go to FETCH.
  - Misaligned addresses are passed through unchanged; alignment is the memory's responsibility.
- WB: rf[rd]<=(load ? MDR : ALUOUT), suppressed when rd=0; go to FETCH.
- Instruction latency with zero wait states:
  - ALU, JAL: 4 cycles.
  - Load: 5 cycles.
  - Store, branch: 4 cycles / 3 cycles respectively (store FETCH-DECODE-EXEC-MEM; branch FETCH-DECODE-EXEC).
  - Each wait cycle adds 1.
- HALT: halted=1; no requests issued; PC frozen at the faulting instruction. Exit only via reset.
- Reset mid-handshake: req drops immediately (asynchronous). The memory must discard the pending access.
- ready asserted while req=0 is ignored.
- Register reads in DECODE see any WB from the prior instruction, because WB completes before the next FETCH.

Optional Feature:
- Macro MC_DATAPATH_RETIRE_CNT_EN.
- Defined:
  - Adds output port instret (64 bits), reset to 0.
  - Increments by 1 on the edge that completes an instruction: WB, store MEM with ready, or branch EXEC.
  - Wraps at 2^64. Does not increment in HALT.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package mc_pkg:
  - FSM state enum (FETCH, DECODE, EXEC, MEM, WB, HALT).
  - Opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL).
  - ALU-op enum.
  - dmem_size encodings.
- One sub-module: mc_alu, combinational, DWIDTH-parametrised, taking the ALU-op enum.
- Register file and FSM stay inline.

Test Plan:
- Zero-wait ADDI x1,x0,5 then ADD x2,x1,x1 -> x2=10; each instruction takes 4 cycles; PC=8 after cycle 8.
- Fetch with imem_ready delayed 3 cycles -> imem_addr stable throughout; the instruction completes 3 cycles later than nominal.
- SW x2,4(x0) then LB x3,4(x0), with memory returning 0x000000F0 -> store presents addr=4, we=1, size=10, wdata=10; x3=0xFFFFFFF0. LBU gives 0x000000F0.
- BNE x1,x0,-8 with x1=5 -> PC moves back 8 in 3 cycles; BEQ with x1=5 -> PC+4.
- ADDI x0,x0,7 -> x0 reads back 0. Opcode 0x7F -> halted=1, no further imem_req, pc_out frozen.
- Async reset asserted mid-MEM with dmem_req=1 -> dmem_req=0 before the next edge. After release: PC=RESET_PC, FETCH restarts, instret=0 when the retire counter is compiled in.
